intra_residual_decoder: RTL
===========================

Name: intra_residual_decoder

Overview:
- Decoder-side counterpart to the intra transform coder. It accepts a stream of quantized 4x4 coefficient levels and applies H.264-style inverse quantization and the 4x4 inverse integer transform.
- It presents the 16 reconstructed residuals in parallel to the prediction adder.
- It sits between the entropy-decode/level unpacker and the decoder reconstructor. It is used once per luma 4x4 block and once per chroma quadrant.

Parameters:
- QP, 2, quantization parameter (0..51), fixed at elaboration.
- RES_W, 9, signed width of each output residual.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous active-low reset
- in_valid  input  1  coefficient level valid
- in_ready  output  1  block can accept a level this cycle
- in_level  input  8  signed quantized level, raster order (index = row*4+col)
- out_valid  output  1  16 residuals valid
- out_ready  input  1  downstream accepts residual block
- out_res  output  16*RES_W  residual k at out_res[k*RES_W +: RES_W], raster order

Behaviour:
- Reset (reset=0, asynchronous): state=COLLECT, coef counter=0, in_ready=1, out_valid=0, out_res=0. All internal coefficient registers are cleared.
- FSM states: COLLECT, DEQ, HPASS, VPASS, OUT.
- COLLECT:
  - in_ready=1. A level is accepted on any posedge with in_valid&in_ready; it is stored at the counter index and the counter increments.
  - On accepting index 15 the counter wraps to 0 and the FSM goes to DEQ.
- DEQ (1 cycle), in_ready=0:
  - d[k] = level[k]*v << (QP/6), 24-bit signed.
  - v is taken from row QP%6 of {10,13,16},{11,14,18},{13,16,20},{14,18,23},{16,20,25},{18,23,29}.
  - Column v0 applies when row and col are both even; v2 when both are odd; v1 otherwise.
- HPASS (1 cycle): per row (d0,d1,d2,d3):
  - e0=d0+d2, e1=d0-d2, e2=(d1>>>1)-d3, e3=d1+(d3>>>1).
  - f = {e0+e3, e1+e2, e1-e2, e0-e3}.
- VPASS (1 cycle):
  - Same butterfly per column on f.
  - r = (x+32)>>>6, arithmetic shift.
  - Saturate to [-(2^(RES_W-1)), 2^(RES_W-1)-1] and register into out_res.
  - Go to OUT.
- OUT:
  - out_valid=1; out_res is held stable and in_ready=0.
  - On a posedge with out_ready=1: out_valid drops, go to COLLECT, and in_ready=1 from the next cycle.
- Latency: out_valid is high 3 clocks after the edge that accepted index 15.
- Throughput: one block per 16+3+1 cycles minimum. There is no overlap between output and collection.
- in_valid while in_ready=0 is ignored; the level is neither stored nor counted.
- A reset asserted in any state aborts the block immediately. Partial coefficients are discarded; the next accepted level is index 0.
- out_res holds its last value after handshake until the next VPASS.

Optional Feature:
- Macro: INTRADEC_NZ_COUNT_EN.
- Defined:
  - Adds output port out_nz (5 bits), the count of nonzero levels accepted in the current block (0..16).
  - It is registered at VPASS, valid with out_valid, and cleared to 0 on reset.
  - The collection count restarts at 0 each block.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- All 16 levels 0, QP=2 -> out_valid 3 clocks after the 16th accept; all out_res = 0; in_ready=0 until the handshake.
- QP=2, level[0]=20, others 0 -> d0=260; all 16 residuals = (260+32)>>6 = 4.
- QP=51 instance, level[0]=127 -> d0 = 127*14<<8 = 455168, so all residuals saturate to 255. With level[0]=-128, all residuals = -256.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid stays 1, out_res unchanged, and in_valid pulses are ignored. Raise out_ready: one handshake, then in_ready=1 the next cycle.
- Drop reset for 1 cycle after 7 levels accepted -> in_ready=1, out_valid=0, counter=0. A following 16-level block gives the same result as from power-up.
- With INTRADEC_NZ_COUNT_EN, levels {3,0,-1,0,...,0,5 at index 15} -> out_nz=3. The next all-zero block gives out_nz=0.

Source files
------------

// File: rtl/intra_residual_decoder.sv
// intra_residual_decoder
//   Collects 16 quantized 4x4 levels in raster order, applies H.264-style
//   inverse quantization and the 4x4 inverse integer transform, and presents
//   the 16 reconstructed residuals in parallel.
//
// Parameters
//   QP     quantization parameter (0..51), fixed at elaboration
//   RES_W  signed width of each output residual
//
// Ports
//   clk_i        clock, all state updates on posedge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   coefficient level valid
//   in_ready_o   a level can be accepted this cycle
//   in_level_i   signed 8-bit level, raster order (index = row*4+col)
//   out_valid_o  16 residuals valid
//   out_ready_i  downstream accepts the residual block
//   out_res_o    residual k at out_res_o[k*RES_W +: RES_W]
//   out_nz_o     (only with INTRADEC_NZ_COUNT_EN) nonzero levels in the block
//
// Optional feature macro: INTRADEC_NZ_COUNT_EN
module intra_residual_decoder #(
    parameter int unsigned QP    = 2,
    parameter int unsigned RES_W = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [7:0]           in_level_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [16*RES_W-1:0]  out_res_o
`ifdef INTRADEC_NZ_COUNT_EN
    ,
    output logic [4:0]           out_nz_o
`endif
);

    // Dequantized values fit in 24 bits; the two butterfly passes add
    // up to ~12x gain, so intermediates carry 28 bits.
    localparam int unsigned CW = 28;

    function automatic int vtab(input int unsigned rem, input int unsigned col);
        int r;
        case (rem)
            0:       r = (col == 0) ? 10 : (col == 1) ? 13 : 16;
            1:       r = (col == 0) ? 11 : (col == 1) ? 14 : 18;
            2:       r = (col == 0) ? 13 : (col == 1) ? 16 : 20;
            3:       r = (col == 0) ? 14 : (col == 1) ? 18 : 23;
            4:       r = (col == 0) ? 16 : (col == 1) ? 20 : 25;
            default: r = (col == 0) ? 18 : (col == 1) ? 23 : 29;
        endcase
        return r;
    endfunction

    localparam int unsigned QpRem = QP % 6;
    localparam int unsigned QpDiv = QP / 6;
    localparam int          V0    = vtab(QpRem, 0);
    localparam int          V1    = vtab(QpRem, 1);
    localparam int          V2    = vtab(QpRem, 2);

    localparam logic signed [CW-1:0] ResMax = CW'((1 << (RES_W - 1)) - 1);
    localparam logic signed [CW-1:0] ResMin = ~ResMax;

    // One 1-D inverse transform; f0 lands in the low slice.
    function automatic logic [4*CW-1:0] bfly(input logic signed [CW-1:0] a0,
                                             input logic signed [CW-1:0] a1,
                                             input logic signed [CW-1:0] a2,
                                             input logic signed [CW-1:0] a3);
        logic signed [CW-1:0] e0, e1, e2, e3;
        e0 = a0 + a2;
        e1 = a0 - a2;
        e2 = (a1 >>> 1) - a3;
        e3 = a1 + (a3 >>> 1);
        return {e0 - e3, e1 - e2, e1 + e2, e0 + e3};
    endfunction

    // Round, arithmetic shift by 6, clamp to the residual range.
    function automatic logic [RES_W-1:0] rnd_sat(input logic signed [CW-1:0] x);
        logic signed [CW-1:0] y;
        y = (x + CW'(32)) >>> 6;
        if (y > ResMax) begin
            y = ResMax;
        end else if (y < ResMin) begin
            y = ResMin;
        end
        return y[RES_W-1:0];
    endfunction

    typedef enum logic [2:0] {StCollect, StDeq, StHpass, StVpass, StOut} state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [16*RES_W-1:0]   out_res_q;
    // Holds levels, then dequantized values, then row-transformed values.
    logic signed [CW-1:0]  coef_q [16];

    logic signed [CW-1:0]  deq_val [16];
    logic signed [CW-1:0]  hp_val [16];
    logic [16*RES_W-1:0]   vp_val;

    always_comb begin
        logic [4*CW-1:0]      tmp;
        logic signed [CW-1:0] vsel;
        tmp    = '0;
        vsel   = '0;
        vp_val = '0;
        for (int k = 0; k < 16; k++) begin
            deq_val[k] = '0;
            hp_val[k]  = '0;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r[0] == 1'b0 && c[0] == 1'b0) begin
                    vsel = CW'(V0);
                end else if (r[0] == 1'b1 && c[0] == 1'b1) begin
                    vsel = CW'(V2);
                end else begin
                    vsel = CW'(V1);
                end
                deq_val[r*4+c] = (coef_q[r*4+c] * vsel) <<< QpDiv;
            end
        end
        for (int r = 0; r < 4; r++) begin
            tmp = bfly(coef_q[r*4], coef_q[r*4+1], coef_q[r*4+2], coef_q[r*4+3]);
            for (int j = 0; j < 4; j++) begin
                hp_val[r*4+j] = tmp[j*CW +: CW];
            end
        end
        for (int c = 0; c < 4; c++) begin
            tmp = bfly(coef_q[c], coef_q[4+c], coef_q[8+c], coef_q[12+c]);
            for (int j = 0; j < 4; j++) begin
                vp_val[(j*4+c)*RES_W +: RES_W] = rnd_sat(tmp[j*CW +: CW]);
            end
        end
    end

`ifdef INTRADEC_NZ_COUNT_EN
    logic [4:0] nz_cnt_q;
    logic [4:0] nz_q;
    assign out_nz_o = nz_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StCollect;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            for (int k = 0; k < 16; k++) begin
                coef_q[k] <= '0;
            end
`ifdef INTRADEC_NZ_COUNT_EN
            nz_cnt_q    <= '0;
            nz_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (in_valid_i && in_ready_q) begin
                        coef_q[cnt_q] <= CW'($signed(in_level_i));
                        cnt_q         <= cnt_q + 4'd1;
`ifdef INTRADEC_NZ_COUNT_EN
                        if (in_level_i != 8'd0) begin
                            nz_cnt_q <= nz_cnt_q + 5'd1;
                        end
`endif
                        if (cnt_q == 4'd15) begin
                            state_q    <= StDeq;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                StDeq: begin
                    for (int k = 0; k < 16; k++) begin
                        coef_q[k] <= deq_val[k];
                    end
                    state_q <= StHpass;
                end
                StHpass: begin
                    for (int k = 0; k < 16; k++) begin
                        coef_q[k] <= hp_val[k];
                    end
                    state_q <= StVpass;
                end
                StVpass: begin
                    out_res_q   <= vp_val;
                    out_valid_q <= 1'b1;
`ifdef INTRADEC_NZ_COUNT_EN
                    nz_q        <= nz_cnt_q;
                    nz_cnt_q    <= '0;
`endif
                    state_q     <= StOut;
                end
                StOut: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StCollect;
                    end
                end
                default: begin
                    state_q <= StCollect;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_res_o   = out_res_q;

endmodule
